alu_serial_adder: RTL

//  Multi-cycle chunked adder computing sum = a_in + b_in + cin. It adds CHUNK bits per clock

---
 rtl/alu_serial_adder_if.sv | 25 ++
 rtl/alu_serial_adder.sv | 90 +++++++++
 2 files changed

// File: rtl/alu_serial_adder_if.sv
// Handshake and operand/result bundle for the chunked serial adder.
// The master drives the request and operands; the slave returns status and the result.
interface alu_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c;
  logic             ovf;

  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum, c, ovf
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum, c, ovf
  );
endinterface

// File: rtl/alu_serial_adder.sv
// Multi-cycle adder: sum = a + b + cin, CHUNK bits per clock, with carry-out and signed overflow.
// state | meaning
// IDLE  | waiting for start
// RUN   | adding one chunk per clock, LSB chunk first
// DONE  | one-cycle result pulse; a new start is accepted here as in IDLE
module alu_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_serial_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, work, work_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry, c_q, ovf_q;
  logic [IDXW-1:0]  idx;
  logic [CHUNK-1:0] part;
  logic             cout, msb_cin;
  logic             accept, last_step;

  assign accept    = (state != RUN) && bus.start;
  assign last_step = (state == RUN) && (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Carry into the chunk's top bit is recovered from its sum bit, so ovf needs no extra adder.
  always_comb begin
    {cout, part} = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    msb_cin      = a_sh[CHUNK-1] ^ b_sh[CHUNK-1] ^ part[CHUNK-1];
    work_nxt     = work;
    work_nxt[idx*CHUNK +: CHUNK] = part;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      work  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a_in;
      b_sh  <= bus.b_in;
      work  <= '0;
      carry <= bus.cin;
      idx   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> CHUNK;
      b_sh  <= b_sh >> CHUNK;
      work  <= work_nxt;
      carry <= cout;
      idx   <= idx + 1'b1;
      if (last_step) begin
        sum_q <= work_nxt;
        c_q   <= cout;
        ovf_q <= msb_cin ^ cout;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.c    = c_q;
  assign bus.ovf  = ovf_q;
endmodule
